spidac_rx: RTL and testbench
============================

Name: spidac_rx

Overview:
- SPI receiver and monitor for the DAC serial link (SCK, nCS, SDI, nLDAC) that spidac drives.
- Oversamples the link in the clock50Mhz domain, deserialises MSB-first frames, holds the last complete word, and transfers it to a "loaded" register on the nLDAC falling edge, mimicking the DAC's input and DAC registers.
- Exposes value, counters and status on the shared 8-bit addr/data register bus for the selector.
- Used for loopback self-test of spidac and for checking DAC step sequences over Ethernet/vJTAG.

Parameters:
- FRAME_BITS, 16: bits per valid DAC frame, range 8..16.
- BASE_ADDR, 8'h40: first of the six register addresses (BASE_ADDR..BASE_ADDR+5).

Ports:
- clock50Mhz  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-high reset.
- rx_SCK  in  1  serial clock from the link (asynchronous to clock50Mhz).
- rx_nCS  in  1  chip select, active low.
- rx_SDI  in  1  serial data, MSB first.
- rx_nLDAC  in  1  load strobe, active low.
- addr  in  8  register address from command.
- data  in  8  write data.
- write  in  1  one-cycle write strobe.
- data_out  out  8  read data; 8'h00 when addr is outside BASE_ADDR..BASE_ADDR+5.
- dac_value  out  16  loaded DAC word, zero-extended above FRAME_BITS.
- frame_pulse  out  1  one-cycle pulse per valid frame.
- load_pulse  out  1  one-cycle pulse per nLDAC load.
- frame_err  out  1  one-cycle pulse per malformed frame.

Behaviour:
- Synchronisation: each of the four link inputs passes through a 2-flop synchroniser, then one edge-detect register.
  - Reset state of the synchronisers is idle: SCK=0, nCS=1, SDI=0, nLDAC=1, so no spurious edge follows reset.
  - Supported link timing: SCK high ≥3 clocks and low ≥3 clocks; nCS and nLDAC stable ≥3 clocks.
- Reset values: every output 0; shift register, holding register, bit counter, frame_cnt, err_cnt, load_cnt, pending and overrun all 0. Receiver FSM goes to IDLE.
- Receiver FSM:
  - IDLE -> SHIFT on synchronised nCS falling edge; clear the bit counter and shift register.
  - In SHIFT, each synchronised SCK rising edge shifts SDI into the LSB and increments the bit counter. The counter saturates at FRAME_BITS+1.
  - SHIFT -> IDLE on nCS rising edge.
    - Bit count == FRAME_BITS: copy the shift register to holding; pulse frame_pulse; frame_cnt++; set pending. If pending was already set, also set overrun.
    - Bit count is 1..FRAME_BITS-1 or FRAME_BITS+1: pulse frame_err; err_cnt++; holding unchanged.
    - Bit count 0: ignored, no pulse, no count.
  - Latency: frame_pulse/frame_err is asserted on the 3rd clock50Mhz edge after the first edge that samples rx_nCS high.
- Load:
  - A synchronised nLDAC falling edge copies holding to dac_value, pulses load_pulse, load_cnt++, and clears pending.
  - This applies in any FSM state. nLDAC during SHIFT loads the previous complete frame.
  - Same-cycle frame completion and nLDAC fall: dac_value takes the old holding; holding takes the new word; pending stays 1; overrun is unaffected by the load.
- Counters: 8-bit, saturate at 255 (no wrap).
- Register map, read side (combinational mux on addr, registered output, 1-cycle read latency):
  - BASE+0: dac_value[7:0]
  - BASE+1: dac_value[15:8]
  - BASE+2: frame_cnt
  - BASE+3: err_cnt
  - BASE+4: load_cnt
  - BASE+5: {6'b0, overrun, pending}
- Register map, write side: write with addr==BASE+5 and data[0]=1 clears all three counters, pending and overrun. Other writes are ignored.
  - Clear coincident with a counter or flag event: clear wins.
  - Clear does not affect dac_value, holding or the FSM.
- Reset mid-frame: return to IDLE immediately. After release, the partial frame is discarded silently, because nCS is still low and no falling edge is seen.

Test Plan:
- Send 16-bit frame 0xA5C3 at SCK=5 MHz, then pulse nLDAC -> frame_pulse once; frame_cnt=1; pending=1 until the load; then dac_value=0xA5C3, load_pulse once, BASE+0/1 read 0xC3/0xA5, pending=0.
- Send 15-bit and 17-bit frames -> frame_err twice; err_cnt=2; frame_cnt and dac_value unchanged; a nCS low/high with no SCK gives no events.
- Send frames 0x1111 then 0x2222 without nLDAC -> overrun=1; a following nLDAC loads 0x2222.
- Align nLDAC fall with nCS rise on frame 0x3333 after holding 0x1234 -> dac_value=0x1234, pending=1; second nLDAC -> 0x3333.
- Send 260 valid frames -> frame_cnt=255; write 0x01 to BASE+5 on the same cycle as a frame completion -> all counters 0, status 0x00.
- Assert reset after 8 SCK edges, release with nCS low, finish the frame -> no frame_pulse/frame_err; read of an address outside the map returns 0x00.

Source files
------------

// File: rtl/spidac_rx.sv
// SPI receiver/monitor for the spidac DAC link: oversampled deserialiser with
// DAC-style input/holding and loaded registers, plus a six-entry register window.
module spidac_rx #(
    parameter int unsigned FRAME_BITS = 16,
    parameter logic [7:0]  BASE_ADDR  = 8'h40
) (
    input  logic        clock50Mhz,
    input  logic        reset,
    input  logic        rx_SCK,
    input  logic        rx_nCS,
    input  logic        rx_SDI,
    input  logic        rx_nLDAC,
    input  logic [7:0]  addr,
    input  logic [7:0]  data,
    input  logic        write,
    output logic [7:0]  data_out,
    output logic [15:0] dac_value,
    output logic        frame_pulse,
    output logic        load_pulse,
    output logic        frame_err
);

    localparam int unsigned CNT_W = $clog2(FRAME_BITS + 2);
    localparam logic [CNT_W-1:0] BITS_FULL = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0] BITS_SAT  = CNT_W'(FRAME_BITS + 1);
    localparam logic [7:0] ADDR_STAT = 8'(BASE_ADDR + 8'd5);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t state, state_nxt;

    logic sck_s1, sck_s2, sck_d;
    logic ncs_s1, ncs_s2, ncs_d;
    logic sdi_s1, sdi_s2, sdi_d;
    logic ldac_s1, ldac_s2, ldac_d;
    logic [1:0] settle;
    logic settled_c;
    logic sck_rise_q, ncs_fall_q, ncs_rise_q, ldac_fall_q;

    logic [FRAME_BITS-1:0] shift_q;
    logic [FRAME_BITS-1:0] holding;
    logic [CNT_W-1:0]      bit_cnt;
    logic [7:0]            frame_cnt, err_cnt, load_cnt;
    logic                  pending, overrun;

    logic       start_c, shift_c, frame_ok_c, frame_bad_c, clr_c;
    logic [7:0] off_c, rd_c;
    logic       unused_c;

    assign unused_c  = ^data[7:1];
    // Edges seen while the synchronisers still hold reset values are not real
    assign settled_c = (settle == 2'd3);

    // Synchronisers, edge detect and registered edge strobes
    always_ff @(posedge clock50Mhz or posedge reset) begin
        if (reset) begin
            sck_s1      <= 1'b0; sck_s2  <= 1'b0; sck_d  <= 1'b0;
            ncs_s1      <= 1'b1; ncs_s2  <= 1'b1; ncs_d  <= 1'b1;
            sdi_s1      <= 1'b0; sdi_s2  <= 1'b0; sdi_d  <= 1'b0;
            ldac_s1     <= 1'b1; ldac_s2 <= 1'b1; ldac_d <= 1'b1;
            settle      <= 2'd0;
            sck_rise_q  <= 1'b0;
            ncs_fall_q  <= 1'b0;
            ncs_rise_q  <= 1'b0;
            ldac_fall_q <= 1'b0;
        end else begin
            sck_s1  <= rx_SCK;   sck_s2  <= sck_s1;  sck_d  <= sck_s2;
            ncs_s1  <= rx_nCS;   ncs_s2  <= ncs_s1;  ncs_d  <= ncs_s2;
            sdi_s1  <= rx_SDI;   sdi_s2  <= sdi_s1;  sdi_d  <= sdi_s2;
            ldac_s1 <= rx_nLDAC; ldac_s2 <= ldac_s1; ldac_d <= ldac_s2;
            if (!settled_c) begin
                settle <= settle + 2'd1;
            end
            sck_rise_q  <= settled_c &  sck_s2  & ~sck_d;
            ncs_fall_q  <= settled_c & ~ncs_s2  &  ncs_d;
            ncs_rise_q  <= settled_c &  ncs_s2  & ~ncs_d;
            ldac_fall_q <= settled_c & ~ldac_s2 &  ldac_d;
        end
    end

    // Receiver state register
    always_ff @(posedge clock50Mhz or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Receiver next state and frame classification
    always_comb begin
        state_nxt   = state;
        start_c     = 1'b0;
        shift_c     = 1'b0;
        frame_ok_c  = 1'b0;
        frame_bad_c = 1'b0;
        case (state)
            IDLE: begin
                if (ncs_fall_q) begin
                    state_nxt = SHIFT;
                    start_c   = 1'b1;
                end
            end
            SHIFT: begin
                if (ncs_rise_q) begin
                    state_nxt = IDLE;
                    if (bit_cnt == BITS_FULL) begin
                        frame_ok_c = 1'b1;
                    end else if (bit_cnt != '0) begin
                        frame_bad_c = 1'b1;
                    end
                end else if (sck_rise_q) begin
                    shift_c = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign clr_c = write && (addr == ADDR_STAT) && data[0];
    assign off_c = addr - BASE_ADDR;

    // Register window read mux
    always_comb begin
        rd_c = 8'h00;
        case (off_c)
            8'd0:    rd_c = dac_value[7:0];
            8'd1:    rd_c = dac_value[15:8];
            8'd2:    rd_c = frame_cnt;
            8'd3:    rd_c = err_cnt;
            8'd4:    rd_c = load_cnt;
            8'd5:    rd_c = {6'b0, overrun, pending};
            default: rd_c = 8'h00;
        endcase
    end

    // Datapath, counters, status and registered outputs
    always_ff @(posedge clock50Mhz or posedge reset) begin
        if (reset) begin
            shift_q     <= '0;
            holding     <= '0;
            bit_cnt     <= '0;
            frame_cnt   <= 8'd0;
            err_cnt     <= 8'd0;
            load_cnt    <= 8'd0;
            pending     <= 1'b0;
            overrun     <= 1'b0;
            dac_value   <= 16'd0;
            data_out    <= 8'd0;
            frame_pulse <= 1'b0;
            load_pulse  <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            frame_pulse <= frame_ok_c;
            frame_err   <= frame_bad_c;
            load_pulse  <= ldac_fall_q;
            data_out    <= rd_c;

            if (start_c) begin
                shift_q <= '0;
                bit_cnt <= '0;
            end else if (shift_c) begin
                shift_q <= {shift_q[FRAME_BITS-2:0], sdi_d};
                if (bit_cnt != BITS_SAT) begin
                    bit_cnt <= bit_cnt + CNT_W'(1);
                end
            end

            // Load samples the old holding value even when a frame lands this cycle
            if (frame_ok_c) begin
                holding <= shift_q;
            end
            if (ldac_fall_q) begin
                dac_value <= 16'(holding);
            end

            if (clr_c) begin
                frame_cnt <= 8'd0;
                err_cnt   <= 8'd0;
                load_cnt  <= 8'd0;
                pending   <= 1'b0;
                overrun   <= 1'b0;
            end else begin
                if (frame_ok_c && frame_cnt != 8'hFF) begin
                    frame_cnt <= frame_cnt + 8'd1;
                end
                if (frame_bad_c && err_cnt != 8'hFF) begin
                    err_cnt <= err_cnt + 8'd1;
                end
                if (ldac_fall_q && load_cnt != 8'hFF) begin
                    load_cnt <= load_cnt + 8'd1;
                end
                if (frame_ok_c) begin
                    pending <= 1'b1;
                    if (pending) begin
                        overrun <= 1'b1;
                    end
                end else if (ldac_fall_q) begin
                    pending <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_spidac_rx.sv
// Directed bench for spidac_rx: drives the SPI link and register bus, checks
// against an event-level model of the DAC registers every cycle.
module tb_spidac_rx;

    localparam int unsigned FB   = 16;
    localparam logic [7:0]  BASE = 8'h40;
    localparam int          LAT  = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_SCK = 1'b0, rx_nCS = 1'b1, rx_SDI = 1'b0, rx_nLDAC = 1'b1;
    logic [7:0]  addr = 8'h00, data = 8'h00;
    logic        write = 1'b0;
    logic [7:0]  data_out;
    logic [15:0] dac_value;
    logic        frame_pulse, load_pulse, frame_err;

    spidac_rx #(.FRAME_BITS(FB), .BASE_ADDR(BASE)) dut (
        .clock50Mhz (clk),
        .reset      (rst),
        .rx_SCK     (rx_SCK),
        .rx_nCS     (rx_nCS),
        .rx_SDI     (rx_SDI),
        .rx_nLDAC   (rx_nLDAC),
        .addr       (addr),
        .data       (data),
        .write      (write),
        .data_out   (data_out),
        .dac_value  (dac_value),
        .frame_pulse(frame_pulse),
        .load_pulse (load_pulse),
        .frame_err  (frame_err)
    );

    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    // Model: DAC registers and counters, updated by events the stimulus schedules
    logic [15:0] m_hold = 16'h0, m_dac = 16'h0;
    int          m_fc = 0, m_ec = 0, m_lc = 0;
    bit          m_pend = 0, m_ovr = 0;
    int          ev_kind[int];
    logic [15:0] ev_word[int];
    bit          ev_load[int];
    bit          ev_clr[int];

    bit          armed = 0;
    int          nbits = 0;
    logic [15:0] sh = 16'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int sat(input int v);
        return (v < 255) ? v + 1 : 255;
    endfunction

    function automatic logic [7:0] rd_model(input logic [7:0] a);
        logic [7:0] off;
        off = a - BASE;
        case (off)
            8'd0:    return m_dac[7:0];
            8'd1:    return m_dac[15:8];
            8'd2:    return 8'(m_fc);
            8'd3:    return 8'(m_ec);
            8'd4:    return 8'(m_lc);
            8'd5:    return {6'b0, m_ovr, m_pend};
            default: return 8'h00;
        endcase
    endfunction

    always @(negedge clk) begin : cmp
        logic efp, elp, efe, pend_old;
        if (rst) begin
            m_hold = 16'h0; m_dac = 16'h0;
            m_fc = 0; m_ec = 0; m_lc = 0; m_pend = 0; m_ovr = 0;
            ev_kind.delete(); ev_word.delete(); ev_load.delete(); ev_clr.delete();
        end else begin
            efp = 0; elp = 0; efe = 0;
            pend_old = m_pend;
            if (ev_load.exists(cyc)) begin
                m_dac  = m_hold;
                m_lc   = sat(m_lc);
                m_pend = 0;
                elp    = 1;
                ev_load.delete(cyc);
            end
            if (ev_kind.exists(cyc)) begin
                if (ev_kind[cyc] == 1) begin
                    m_hold = ev_word[cyc];
                    m_fc   = sat(m_fc);
                    if (pend_old) m_ovr = 1;
                    m_pend = 1;
                    efp    = 1;
                end else begin
                    m_ec = sat(m_ec);
                    efe  = 1;
                end
                ev_kind.delete(cyc);
            end
            if (ev_clr.exists(cyc)) begin
                m_fc = 0; m_ec = 0; m_lc = 0; m_pend = 0; m_ovr = 0;
                ev_clr.delete(cyc);
            end
            check("frame_pulse", 32'(frame_pulse), 32'(efp));
            check("load_pulse",  32'(load_pulse),  32'(elp));
            check("frame_err",   32'(frame_err),   32'(efe));
            check("dac_value",   32'(dac_value),   32'(m_dac));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic read_lit(input logic [7:0] a, input logic [7:0] e, input string name);
        addr = a;
        @(negedge clk);
        check(name, 32'(data_out), 32'(e));
    endtask

    task automatic read_model(input logic [7:0] a, input string name);
        logic [7:0] e;
        addr = a;
        #1 e = rd_model(a);
        @(negedge clk);
        check(name, 32'(data_out), 32'(e));
    endtask

    task automatic frame_start();
        rx_nCS = 1'b0;
        armed  = !rst;
        nbits  = 0;
        sh     = 16'h0;
        tick(4);
    endtask

    task automatic send_bits(input logic [31:0] w, input int n, input int half);
        for (int i = n - 1; i >= 0; i--) begin
            rx_SDI = w[i];
            tick(half);
            rx_SCK = 1'b1;
            nbits++;
            sh = {sh[14:0], w[i]};
            tick(half);
            rx_SCK = 1'b0;
        end
    endtask

    task automatic frame_end(input bit with_ldac);
        tick(4);
        rx_nCS = 1'b1;
        if (with_ldac) begin
            rx_nLDAC = 1'b0;
            ev_load[cyc + LAT] = 1;
        end
        if (armed) begin
            if (nbits == FB) begin
                ev_kind[cyc + LAT] = 1;
                ev_word[cyc + LAT] = sh;
            end else if (nbits != 0) begin
                ev_kind[cyc + LAT] = 2;
            end
        end
        armed = 0;
    endtask

    task automatic send_frame(input logic [31:0] w, input int n, input int half);
        frame_start();
        send_bits(w, n, half);
        frame_end(1'b0);
        tick(6);
    endtask

    task automatic ldac();
        rx_nLDAC = 1'b0;
        ev_load[cyc + LAT] = 1;
        tick(4);
        rx_nLDAC = 1'b1;
        tick(6);
    endtask

    initial begin
        tick(3);
        check("rst_dac_value",   32'(dac_value),   32'h0);
        check("rst_frame_pulse", 32'(frame_pulse), 32'h0);
        check("rst_load_pulse",  32'(load_pulse),  32'h0);
        check("rst_frame_err",   32'(frame_err),   32'h0);
        check("rst_data_out",    32'(data_out),    32'h0);
        #2 rst = 1'b0;
        tick(5);
        read_lit(BASE + 8'd2, 8'h00, "rst_frame_cnt");
        read_lit(BASE + 8'd5, 8'h00, "rst_status");

        // Single frame, then load
        send_frame(32'hA5C3, 16, 5);
        read_lit(BASE + 8'd2, 8'h01, "t1_frame_cnt");
        read_lit(BASE + 8'd5, 8'h01, "t1_pending");
        ldac();
        check("t1_dac", 32'(dac_value), 32'hA5C3);
        read_lit(BASE + 8'd0, 8'hC3, "t1_dac_lo");
        read_lit(BASE + 8'd1, 8'hA5, "t1_dac_hi");
        read_lit(BASE + 8'd4, 8'h01, "t1_load_cnt");
        read_lit(BASE + 8'd5, 8'h00, "t1_status");

        // Short, long and empty frames
        send_frame(32'h5A5A, 15, 5);
        send_frame(32'h1FFFF, 17, 5);
        send_frame(32'h0, 0, 5);
        read_lit(BASE + 8'd3, 8'h02, "t2_err_cnt");
        read_lit(BASE + 8'd2, 8'h01, "t2_frame_cnt");
        check("t2_dac", 32'(dac_value), 32'hA5C3);

        // Overrun
        send_frame(32'h1111, 16, 5);
        send_frame(32'h2222, 16, 5);
        read_lit(BASE + 8'd5, 8'h03, "t3_status");
        ldac();
        check("t3_dac", 32'(dac_value), 32'h2222);
        read_lit(BASE + 8'd5, 8'h02, "t3_status_after");

        // Load coincident with frame completion
        send_frame(32'h1234, 16, 5);
        frame_start();
        send_bits(32'h3333, 16, 5);
        frame_end(1'b1);
        tick(4);
        rx_nLDAC = 1'b1;
        tick(6);
        check("t4_dac_old", 32'(dac_value), 32'h1234);
        read_lit(BASE + 8'd5, 8'h03, "t4_status");
        ldac();
        check("t4_dac_new", 32'(dac_value), 32'h3333);
        for (int a = 0; a < 6; a++) read_model(8'(BASE + 8'(a)), "t4_reg");

        // Counter saturation and clear coincident with a frame
        for (int i = 0; i < 259; i++) send_frame(32'(16'h0100 + 16'(i)), 16, 3);
        read_lit(BASE + 8'd2, 8'hFF, "t5_frame_sat");
        frame_start();
        send_bits(32'hBEEF, 16, 3);
        frame_end(1'b0);
        tick(3);
        addr  = BASE + 8'd5;
        data  = 8'h01;
        write = 1'b1;
        ev_clr[cyc + 1] = 1;
        tick(1);
        write = 1'b0;
        data  = 8'h00;
        tick(6);
        read_lit(BASE + 8'd2, 8'h00, "t5_frame_cnt");
        read_lit(BASE + 8'd3, 8'h00, "t5_err_cnt");
        read_lit(BASE + 8'd4, 8'h00, "t5_load_cnt");
        read_lit(BASE + 8'd5, 8'h00, "t5_status");
        check("t5_dac_kept", 32'(dac_value), 32'h3333);
        ldac();
        check("t5_dac_beef", 32'(dac_value), 32'hBEEF);
        read_lit(BASE + 8'd4, 8'h01, "t5_load_cnt_after");

        // Reset in the middle of a frame
        frame_start();
        send_bits(32'hF0, 8, 5);
        tick(2);
        #2 rst = 1'b1;
        armed = 0;
        tick(3);
        #2 rst = 1'b0;
        send_bits(32'h0F, 8, 5);
        frame_end(1'b0);
        tick(8);
        read_lit(BASE + 8'd2, 8'h00, "t6_frame_cnt");
        read_lit(BASE + 8'd3, 8'h00, "t6_err_cnt");
        check("t6_dac", 32'(dac_value), 32'h0);
        read_lit(8'h10, 8'h00, "oob_low");
        read_lit(BASE + 8'd6, 8'h00, "oob_high");
        tick(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
